// File: rtl/buffer_pkgs.sv
// Shared types for the branch recovery path: writeback record, checkpoint
// snapshot, recovery FSM states and the ROB age helper.
package buffer_pkgs;

    localparam int unsigned PREGS    = 64;
    localparam int unsigned PREG_W   = $clog2(PREGS);
    localparam int unsigned FL_CNT_W = $clog2(PREGS) + 1;
    // Snapshot/record field widths track the default ROB_DEPTH (16) and AREG (32)
    localparam int unsigned ROB_W_D  = 4;
    localparam int unsigned AREG_D   = 32;

    typedef struct packed {
        logic [ROB_W_D-1:0] rob_tag;
        logic               mispredict;
        logic [31:0]        dest_addr;
    } branch_out_t;

    typedef struct packed {
        logic [ROB_W_D-1:0]       rob_tag;
        logic [AREG_D*PREG_W-1:0] rat_map;
        logic [PREG_W-1:0]        fl_head;
        logic [PREG_W-1:0]        fl_tail;
        logic [FL_CNT_W-1:0]      fl_count;
        logic [ROB_W_D-1:0]       rob_tail;
        logic [ROB_W_D:0]         rob_used;
    } chkpt_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        HOLD
    } rec_state_e;

    function automatic logic [ROB_W_D-1:0] rob_age(input logic [ROB_W_D-1:0] tag,
                                                   input logic [ROB_W_D-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/oldest_select.sv
// Picks the oldest (smallest age) of N valid requesters; ties go to the lower index.
module oldest_select #(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]         valid_i,
    input  logic [N-1:0][AW-1:0] age_i,
    output logic [IW-1:0]        win_idx_o,
    output logic [AW-1:0]        win_age_o,
    output logic                 win_valid_o
);

    logic          found;
    logic [IW-1:0] idx;
    logic [AW-1:0] best;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid_i[i] && (!found || age_i[i] < best)) begin
                found = 1'b1;
                idx   = IW'(i);
                best  = age_i[i];
            end
        end
        win_valid_o = found;
        win_idx_o   = idx;
        win_age_o   = best;
    end

endmodule

// File: rtl/branch_recovery_unit.sv
// Checkpoint-pooled branch recovery: allocates snapshot slots, resolves branch
// writebacks on several ports and restores ROB/RAT/free list on a mispredict.
module branch_recovery_unit
    import buffer_pkgs::*;
#(
    parameter int unsigned ROB_DEPTH  = 16,
    parameter int unsigned AREG       = 32,
    parameter int unsigned PREGS      = buffer_pkgs::PREGS,
    parameter int unsigned PREG_W     = buffer_pkgs::PREG_W,
    parameter int unsigned N_BR_PORTS = 2,
    parameter int unsigned N_CHKPT    = 8,
    parameter int unsigned FLUSH_HOLD = 2,
    localparam int unsigned ROB_W     = $clog2(ROB_DEPTH),
    localparam int unsigned CID_W     = $clog2(N_CHKPT),
    localparam int unsigned FC_W      = $clog2(PREGS) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [ROB_W-1:0]                 rob_head_i,
    input  logic                             alloc_req_i,
    input  logic [ROB_W-1:0]                 alloc_rob_tag_i,
    input  logic [AREG*PREG_W-1:0]           alloc_rat_map_i,
    input  logic [PREG_W-1:0]                alloc_fl_head_i,
    input  logic [PREG_W-1:0]                alloc_fl_tail_i,
    input  logic [FC_W-1:0]                  alloc_fl_count_i,
    input  logic [ROB_W-1:0]                 alloc_rob_tail_i,
    input  logic [ROB_W:0]                   alloc_rob_used_i,
    output logic                             alloc_gnt_o,
    output logic [CID_W-1:0]                 alloc_id_o,
    output logic                             chkpt_full_o,
    input  logic [N_BR_PORTS-1:0]            br_wb_valid_i,
    input  branch_out_t [N_BR_PORTS-1:0]     br_wb_i,
    output logic                             flush_o,
    output logic                             redirect_valid_o,
    output logic                             rob_recover_o,
    output logic                             rat_recover_o,
    output logic                             fl_recover_o,
    output logic [31:0]                      redirect_pc_o,
    output logic [ROB_W-1:0]                 rob_recover_tail_o,
    output logic [ROB_W:0]                   rob_recover_used_o,
    output logic [AREG*PREG_W-1:0]           rat_recover_map_o,
    output logic [PREG_W-1:0]                fl_recover_head_o,
    output logic [PREG_W-1:0]                fl_recover_tail_o,
    output logic [FC_W-1:0]                  fl_recover_free_count_o,
    output logic [ROB_W-1:0]                 recover_rob_tag_o,
    output logic                             recover_busy_o,
    output logic                             err_lookup_o
);

    localparam int unsigned PW     = (N_BR_PORTS > 1) ? $clog2(N_BR_PORTS) : 1;
    localparam int unsigned HOLD_W = $clog2(FLUSH_HOLD + 1);

    rec_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_CHKPT-1:0]  slot_valid_q, slot_valid_d;
    chkpt_t              slot_q [N_CHKPT];
    chkpt_t              slot_d [N_CHKPT];
    chkpt_t              rec_q, rec_d;
    logic [31:0]         rec_pc_q, rec_pc_d;
    logic                err_q, err_d;

    logic [N_BR_PORTS-1:0]            hit, fire, correct;
    logic [N_BR_PORTS-1:0][CID_W-1:0] hit_idx;
    logic [N_BR_PORTS-1:0][ROB_W-1:0] port_age;
    logic [PW-1:0]                    win_port;
    logic [ROB_W-1:0]                 win_age, rec_age;
    logic                             win_valid, accept, alloc_free;

    // Tag CAM over valid slots, per writeback port
    always_comb begin
        hit      = '0;
        hit_idx  = '0;
        fire     = '0;
        correct  = '0;
        port_age = '0;
        for (int unsigned p = 0; p < N_BR_PORTS; p++) begin
            for (int unsigned s = 0; s < N_CHKPT; s++) begin
                if (slot_valid_q[s] && slot_q[s].rob_tag == br_wb_i[p].rob_tag) begin
                    hit[p]     = 1'b1;
                    hit_idx[p] = CID_W'(s);
                end
            end
            fire[p]     = br_wb_valid_i[p] & br_wb_i[p].mispredict & hit[p];
            correct[p]  = br_wb_valid_i[p] & ~br_wb_i[p].mispredict & hit[p];
            port_age[p] = rob_age(br_wb_i[p].rob_tag, rob_head_i);
        end
    end

    oldest_select #(
        .N  (N_BR_PORTS),
        .AW (ROB_W),
        .IW (PW)
    ) u_oldest_select (
        .valid_i     (fire),
        .age_i       (port_age),
        .win_idx_o   (win_port),
        .win_age_o   (win_age),
        .win_valid_o (win_valid)
    );

    // While recovering, only a strictly older mispredict restarts the flush
    assign rec_age = rob_age(rec_q.rob_tag, rob_head_i);
    assign accept  = win_valid & ((state_q == IDLE) | (win_age < rec_age));

    always_comb begin
        alloc_id_o = '0;
        alloc_free = 1'b0;
        for (int unsigned s = 0; s < N_CHKPT; s++) begin
            if (!slot_valid_q[s] && !alloc_free) begin
                alloc_free = 1'b1;
                alloc_id_o = CID_W'(s);
            end
        end
    end

    assign chkpt_full_o = &slot_valid_q;
    assign alloc_gnt_o  = alloc_req_i & ~chkpt_full_o & (state_q == IDLE) & ~(|fire);

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        rec_d        = rec_q;
        rec_pc_d     = rec_pc_q;
        err_d        = err_q | (|(br_wb_valid_i & ~hit));
        for (int unsigned p = 0; p < N_BR_PORTS; p++) begin
            if (correct[p]) slot_valid_d[hit_idx[p]] = 1'b0;
        end
        if (accept) begin
            for (int unsigned s = 0; s < N_CHKPT; s++) begin
                if (slot_valid_q[s] && rob_age(slot_q[s].rob_tag, rob_head_i) > win_age)
                    slot_valid_d[s] = 1'b0;
            end
            slot_valid_d[hit_idx[win_port]] = 1'b0;
            rec_d    = slot_q[hit_idx[win_port]];
            rec_pc_d = br_wb_i[win_port].dest_addr;
        end
        if (alloc_gnt_o) begin
            slot_valid_d[alloc_id_o] = 1'b1;
            slot_d[alloc_id_o] = '{rob_tag:  alloc_rob_tag_i,
                                   rat_map:  alloc_rat_map_i,
                                   fl_head:  alloc_fl_head_i,
                                   fl_tail:  alloc_fl_tail_i,
                                   fl_count: alloc_fl_count_i,
                                   rob_tail: alloc_rob_tail_i,
                                   rob_used: alloc_rob_used_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = FLUSH;
            FLUSH: begin
                if (!accept) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_W'(FLUSH_HOLD - 1);
                end
            end
            HOLD: begin
                if (accept)                 state_d = FLUSH;
                else if (hold_cnt_q == '0)  state_d = IDLE;
                else                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            slot_valid_q <= '0;
            rec_q        <= '0;
            rec_pc_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            slot_valid_q <= slot_valid_d;
            rec_q        <= rec_d;
            rec_pc_q     <= rec_pc_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        slot_q <= slot_d;
    end

    assign flush_o                 = (state_q == FLUSH);
    assign redirect_valid_o        = (state_q == FLUSH);
    assign rob_recover_o           = (state_q == FLUSH);
    assign rat_recover_o           = (state_q == FLUSH);
    assign fl_recover_o            = (state_q == FLUSH);
    assign recover_busy_o          = (state_q != IDLE);
    assign redirect_pc_o           = rec_pc_q;
    assign rob_recover_tail_o      = rec_q.rob_tail;
    assign rob_recover_used_o      = rec_q.rob_used;
    assign rat_recover_map_o       = rec_q.rat_map;
    assign fl_recover_head_o       = rec_q.fl_head;
    assign fl_recover_tail_o       = rec_q.fl_tail;
    assign fl_recover_free_count_o = rec_q.fl_count;
    assign recover_rob_tag_o       = rec_q.rob_tag;
    assign err_lookup_o            = err_q;

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Directed bench for branch_recovery_unit: a per-cycle vector table plus
// hand sequences for the multi-cycle recovery corner cases.
module tb_branch_recovery_unit;
    import buffer_pkgs::*;

    logic              clk;
    logic              rst;
    logic [3:0]        head;
    logic              alloc_req;
    logic [3:0]        alloc_tag;
    logic [191:0]      alloc_map;
    logic [5:0]        alloc_fl_head, alloc_fl_tail;
    logic [6:0]        alloc_fl_count;
    logic [3:0]        alloc_rob_tail;
    logic [4:0]        alloc_rob_used;
    logic              alloc_gnt;
    logic [2:0]        alloc_id;
    logic              full;
    logic [1:0]        wb_valid;
    branch_out_t [1:0] wb;
    logic              flush, redirect_valid, rob_rec, rat_rec, fl_rec;
    logic [31:0]       redirect_pc;
    logic [3:0]        rec_tail;
    logic [4:0]        rec_used;
    logic [191:0]      rec_map;
    logic [5:0]        rec_fl_head, rec_fl_tail;
    logic [6:0]        rec_fl_count;
    logic [3:0]        rec_tag;
    logic              busy;
    logic              err;

    int tests = 0;
    int fails = 0;

    branch_recovery_unit dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .rob_head_i              (head),
        .alloc_req_i             (alloc_req),
        .alloc_rob_tag_i         (alloc_tag),
        .alloc_rat_map_i         (alloc_map),
        .alloc_fl_head_i         (alloc_fl_head),
        .alloc_fl_tail_i         (alloc_fl_tail),
        .alloc_fl_count_i        (alloc_fl_count),
        .alloc_rob_tail_i        (alloc_rob_tail),
        .alloc_rob_used_i        (alloc_rob_used),
        .alloc_gnt_o             (alloc_gnt),
        .alloc_id_o              (alloc_id),
        .chkpt_full_o            (full),
        .br_wb_valid_i           (wb_valid),
        .br_wb_i                 (wb),
        .flush_o                 (flush),
        .redirect_valid_o        (redirect_valid),
        .rob_recover_o           (rob_rec),
        .rat_recover_o           (rat_rec),
        .fl_recover_o            (fl_rec),
        .redirect_pc_o           (redirect_pc),
        .rob_recover_tail_o      (rec_tail),
        .rob_recover_used_o      (rec_used),
        .rat_recover_map_o       (rec_map),
        .fl_recover_head_o       (rec_fl_head),
        .fl_recover_tail_o       (rec_fl_tail),
        .fl_recover_free_count_o (rec_fl_count),
        .recover_rob_tag_o       (rec_tag),
        .recover_busy_o          (busy),
        .err_lookup_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot contents are a fixed function of the branch tag
    function automatic logic [191:0] map_of(input logic [3:0] t);
        logic [15:0] w;
        w = {t, t, t, t} ^ 16'h5A5A;
        return {12{w}};
    endfunction

    typedef struct {
        logic        rst;
        logic        areq;
        logic [3:0]  atag;
        logic [1:0]  wv;
        logic [3:0]  t0;
        logic        m0;
        logic [31:0] d0;
        logic [3:0]  t1;
        logic        m1;
        logic [31:0] d1;
        logic [3:0]  head;
        logic        e_gnt;
        logic [2:0]  e_id;
        logic        e_full;
        logic        e_flush;
        logic        e_busy;
        logic [3:0]  e_rtag;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic r, input logic areq, input logic [3:0] atag,
                                 input logic [1:0] wv, input logic [3:0] t0, input logic m0,
                                 input logic [31:0] d0, input logic [3:0] t1, input logic m1,
                                 input logic [31:0] d1, input logic [3:0] h,
                                 input logic gnt, input logic [2:0] id, input logic fl,
                                 input logic fsh, input logic bsy, input logic [3:0] rtag,
                                 input logic [31:0] pc, input logic er);
        vec_t v;
        v = '{r, areq, atag, wv, t0, m0, d0, t1, m1, d1, h, gnt, id, fl, fsh, bsy, rtag, pc, er};
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic areq, input logic [3:0] atag,
                         input logic [1:0] wv, input logic [3:0] t0, input logic m0,
                         input logic [31:0] d0, input logic [3:0] t1, input logic m1,
                         input logic [31:0] d1, input logic [3:0] h);
        rst            = r;
        alloc_req      = areq;
        alloc_tag      = atag;
        alloc_map      = map_of(atag);
        alloc_fl_head  = 6'(atag + 4'd1);
        alloc_fl_tail  = 6'(atag) + 6'd33;
        alloc_fl_count = 7'(atag) + 7'd40;
        alloc_rob_tail = atag + 4'd5;
        alloc_rob_used = 5'(atag) + 5'd2;
        wb_valid       = wv;
        wb[0]          = '{rob_tag: t0, mispredict: m0, dest_addr: d0};
        wb[1]          = '{rob_tag: t1, mispredict: m1, dest_addr: d1};
        head           = h;
    endtask

    task automatic idle_in(input logic [3:0] h);
        drive(1'b0, 1'b0, 4'd0, 2'b00, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_restore(input string name, input logic [3:0] t);
        chk({name, " rtag"},  192'(rec_tag), 192'(t));
        chk({name, " map"},   rec_map, map_of(t));
        chk({name, " flh"},   192'(rec_fl_head), 192'(t + 4'd1));
        chk({name, " flt"},   192'(rec_fl_tail), 192'(6'(t) + 6'd33));
        chk({name, " flc"},   192'(rec_fl_count), 192'(7'(t) + 7'd40));
        chk({name, " rtail"}, 192'(rec_tail), 192'(t + 4'd5));
        chk({name, " rused"}, 192'(rec_used), 192'(5'(t) + 5'd2));
    endtask

    task automatic chk_pulses(input string name, input logic e);
        chk({name, " flush"},    192'(flush), 192'(e));
        chk({name, " redirect"}, 192'(redirect_valid), 192'(e));
        chk({name, " rob_rec"},  192'(rob_rec), 192'(e));
        chk({name, " rat_rec"},  192'(rat_rec), 192'(e));
        chk({name, " fl_rec"},   192'(fl_rec), 192'(e));
    endtask

    task automatic chk_all_zero(input string name);
        chk_pulses(name, 1'b0);
        chk({name, " busy"}, 192'(busy), 192'd0);
        chk({name, " err"},  192'(err), 192'd0);
        chk({name, " pc"},   192'(redirect_pc), 192'd0);
        chk({name, " full"}, 192'(full), 192'd0);
        chk({name, " data"}, {rec_map[63:0], 34'd0, rec_tag, rec_tail, rec_used,
                              rec_fl_head, rec_fl_tail, rec_fl_count}, 192'd0);
    endtask

    initial begin
        // Basic alloc / correct-free
        tbl.push_back(row(0,1,4'd3,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 1,3'd0,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,0,4'd0,2'b01,4'd3,0,0,4'd0,0,0,4'd0, 0,3'd1,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 0,3'd0,0, 0,0,4'd0,0,0));
        // Fill all 8 slots with tags 8..15
        for (int i = 0; i < 8; i++)
            tbl.push_back(row(0,1,4'(8 + i),2'b00,4'd0,0,0,4'd0,0,0,4'd0, 1,3'(i),0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,1,4'd2,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 0,3'd0,1, 0,0,4'd0,0,0));
        // Free of tag 10 in this cycle must not grant until the next one
        tbl.push_back(row(0,1,4'd2,2'b01,4'd10,0,0,4'd0,0,0,4'd0, 0,3'd0,1, 0,0,4'd0,0,0));
        tbl.push_back(row(0,1,4'd2,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 1,3'd2,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 0,3'd0,1, 0,0,4'd0,0,0));
        tbl.push_back(row(1,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd0, 0,3'd0,1, 0,0,4'd0,0,0));
        // head=14: slots 15,1,5 then mispredict tag 1 (alloc blocked by fire)
        tbl.push_back(row(0,1,4'd15,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 1,3'd0,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,1,4'd1,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 1,3'd1,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,1,4'd5,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 1,3'd2,0, 0,0,4'd0,0,0));
        tbl.push_back(row(0,1,4'd7,2'b01,4'd1,1,32'h400,4'd0,0,0,4'd14, 0,3'd3,0, 1,1,4'd1,32'h400,0));
        tbl.push_back(row(0,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 0,3'd1,0, 0,1,4'd1,32'h400,0));
        tbl.push_back(row(0,1,4'd7,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 0,3'd1,0, 0,1,4'd1,32'h400,0));
        tbl.push_back(row(0,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 0,3'd1,0, 0,0,4'd1,32'h400,0));
        // Tag 15 retained: correct writeback hits, frees slot 0
        tbl.push_back(row(0,0,4'd0,2'b01,4'd15,0,0,4'd0,0,0,4'd14, 0,3'd1,0, 0,0,4'd1,32'h400,0));
        tbl.push_back(row(0,0,4'd0,2'b00,4'd0,0,0,4'd0,0,0,4'd14, 0,3'd0,0, 0,0,4'd1,32'h400,0));

        idle_in(4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("reset");
        chk("reset gnt", 192'(alloc_gnt), 192'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.rst, v.areq, v.atag, v.wv, v.t0, v.m0, v.d0, v.t1, v.m1, v.d1, v.head);
            #1;
            chk($sformatf("row%0d gnt", i),  192'(alloc_gnt), 192'(v.e_gnt));
            chk($sformatf("row%0d id", i),   192'(alloc_id), 192'(v.e_id));
            chk($sformatf("row%0d full", i), 192'(full), 192'(v.e_full));
            tick();
            chk($sformatf("row%0d flush", i), 192'(flush), 192'(v.e_flush));
            chk($sformatf("row%0d busy", i),  192'(busy), 192'(v.e_busy));
            chk($sformatf("row%0d rtag", i),  192'(rec_tag), 192'(v.e_rtag));
            chk($sformatf("row%0d pc", i),    192'(redirect_pc), 192'(v.e_pc));
            chk($sformatf("row%0d err", i),   192'(err), 192'(v.e_err));
            if (v.e_flush) begin
                chk_pulses($sformatf("row%0d", i), 1'b1);
                chk_restore($sformatf("row%0d", i), v.e_rtag);
            end
        end

        // Same-cycle tie-break on age, then older restart during HOLD
        idle_in(4'd2);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'(2 + 2 * i), 2'b00, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd2);
            tick();
        end
        drive(1'b0, 1'b0, 4'd0, 2'b11, 4'd6, 1'b1, 32'h600, 4'd4, 1'b1, 32'h440, 4'd2);
        tick();
        chk_pulses("tie", 1'b1);
        chk("tie pc", 192'(redirect_pc), 192'(32'h440));
        chk_restore("tie", 4'd4);
        idle_in(4'd2);
        tick();
        chk("hold1 flush", 192'(flush), 192'd0);
        chk("hold1 busy", 192'(busy), 192'd1);
        drive(1'b0, 1'b0, 4'd0, 2'b01, 4'd2, 1'b1, 32'h220, 4'd0, 1'b0, 32'd0, 4'd2);
        tick();
        chk_pulses("reflush", 1'b1);
        chk("reflush pc", 192'(redirect_pc), 192'(32'h220));
        chk_restore("reflush", 4'd2);
        idle_in(4'd2);
        tick();
        chk("hold2 flush", 192'(flush), 192'd0);
        drive(1'b0, 1'b0, 4'd0, 2'b10, 4'd0, 1'b0, 32'd0, 4'd9, 1'b1, 32'h900, 4'd2);
        tick();
        chk("young flush", 192'(flush), 192'd0);
        chk("young busy", 192'(busy), 192'd1);
        chk("young rtag", 192'(rec_tag), 192'd2);
        chk("young pc", 192'(redirect_pc), 192'(32'h220));
        chk("young err", 192'(err), 192'd1);
        idle_in(4'd2);
        tick();
        chk("young idle", 192'(busy), 192'd0);

        // Lookup miss is sticky; reset during HOLD clears everything
        rst = 1'b1;
        tick();
        idle_in(4'd0);
        chk("rst2 err", 192'(err), 192'd0);
        drive(1'b0, 1'b0, 4'd0, 2'b01, 4'd7, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        tick();
        chk("miss err", 192'(err), 192'd1);
        chk("miss flush", 192'(flush), 192'd0);
        drive(1'b0, 1'b1, 4'd5, 2'b00, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        #1;
        chk("b alloc gnt", 192'(alloc_gnt), 192'd1);
        tick();
        chk("sticky err", 192'(err), 192'd1);
        drive(1'b0, 1'b0, 4'd0, 2'b01, 4'd5, 1'b1, 32'h500, 4'd0, 1'b0, 32'd0, 4'd0);
        tick();
        chk("b flush", 192'(flush), 192'd1);
        idle_in(4'd0);
        tick();
        chk("b hold busy", 192'(busy), 192'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_hold");
        alloc_req = 1'b1;
        #1;
        chk("rst_hold gnt", 192'(alloc_gnt), 192'd1);
        chk("rst_hold id", 192'(alloc_id), 192'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_recovery_unit.md
# branch_recovery_unit

Multi-port, checkpoint-pooled successor to the single-port recovery controller. It sits between rename/dispatch and the branch execution ports. It allocates one of N_CHKPT snapshot slots per in-flight branch and resolves up to N_BR_PORTS branch writebacks per cycle. On a misprediction it selects the oldest mispredicted branch, restores the ROB, RAT and free list from that branch's slot, and runs a flush/hold FSM. Younger mispredictions that arrive during the flush are ignored; older ones restart recovery.

## Interface
- ROB_DEPTH, 16, ROB entries; power of two; ROB_W = $clog2(ROB_DEPTH)
- AREG, 32, architectural registers
- PREGS, buffer_pkgs::PREGS, physical registers
- PREG_W, buffer_pkgs::PREG_W, physical register index width
- N_BR_PORTS, 2, branch writeback ports (1..4)
- N_CHKPT, 8, snapshot slots (2..ROB_DEPTH); CID_W = $clog2(N_CHKPT)
- FLUSH_HOLD, 2, cycles recover_busy_o stays high after the restore pulse (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset synchronous and active-high
- rob_head_i  in  ROB_W  oldest ROB entry, used for age compare
- alloc_req_i  in  1  rename requests a checkpoint
- alloc_rob_tag_i  in  ROB_W  branch ROB tag
- alloc_rat_map_i  in  AREG*PREG_W  RAT snapshot
- alloc_fl_head_i / alloc_fl_tail_i  in  PREG_W  free-list pointers
- alloc_fl_count_i  in  $clog2(PREGS)+1  free count
- alloc_rob_tail_i  in  ROB_W;  alloc_rob_used_i  in  ROB_W+1  ROB pointer snapshot
- alloc_gnt_o  out  1  slot written this cycle
- alloc_id_o  out  CID_W  granted slot
- chkpt_full_o  out  1  no free slot
- br_wb_valid_i  in  N_BR_PORTS  per-port valid
- br_wb_i  in  branch_out_t[N_BR_PORTS]  ROB_tag, mispredict, dest_addr
- flush_o, redirect_valid_o, rob_recover_o, rat_recover_o, fl_recover_o  out  1 each  restore pulses
- redirect_pc_o  out  32
- rob_recover_tail_o  out  ROB_W;  rob_recover_used_o  out  ROB_W+1
- rat_recover_map_o  out  AREG*PREG_W
- fl_recover_head_o / fl_recover_tail_o  out  PREG_W;  fl_recover_free_count_o  out  $clog2(PREGS)+1
- recover_rob_tag_o  out  ROB_W
- recover_busy_o  out  1  FSM not IDLE
- err_lookup_o  out  1  sticky: a valid writeback with no matching slot

## Operation
- Each slot holds valid, rob_tag and the full snapshot. Tag match is a CAM over valid slots.
- alloc_gnt_o = alloc_req_i & ~chkpt_full_o & (state==IDLE) & ~mispredict_fire. Combinational.
- alloc_id_o is the lowest-index free slot. The slot is written and marked valid at the clock edge.
- Age: age(t) = (t − rob_head_i) mod ROB_DEPTH. A smaller age is older.
- Correct prediction (valid & ~mispredict & tag hit): the slot is freed next edge.
- mispredict_fire: any port has valid & mispredict & tag hit. Among firing ports, the winner is the minimum age; on a tie, the lower port wins.
- On acceptance of the winner:
  - the winner's slot is freed, along with every valid slot whose age > winner age;
  - correct-prediction frees in the same cycle are still applied.
- A valid writeback with no tag hit sets err_lookup_o, which is cleared only by reset. No recovery occurs for that writeback.
- FSM states and transitions:
  - IDLE → FLUSH on mispredict_fire.
  - FLUSH: all restore pulses high for exactly 1 cycle. Goes to HOLD with hold counter = FLUSH_HOLD−1.
  - HOLD: decrements the counter; at 0 goes to IDLE.
  - In FLUSH or HOLD, a firing mispredict strictly older than the latched recover tag re-enters FLUSH with the new winner. Younger or equal mispredicts are ignored.
- Reset clears all slot valids and returns to IDLE from any state.

## Timing
- Mispredict accepted at edge N. Restore outputs and data are valid during cycle N+1 (registered).
- recover_busy_o is high from cycle N+1 through cycle N+1+FLUSH_HOLD.
- Slot contents are readable one cycle after the alloc edge. A writeback in the alloc cycle does not hit.
- chkpt_full_o is derived from registered valids. A free in the same cycle does not enable a grant until the next cycle.
- Reset value of every output is 0 (err_lookup_o = 0).

## Structure
- buffer_pkgs gains:
  - chkpt_t (rob_tag, rat_map, fl_head, fl_tail, fl_count, rob_tail, rob_used);
  - the state enum {IDLE, FLUSH, HOLD};
  - an rob_age function.
- Sub-module oldest_select: N-input age comparator returning the winner index and a valid flag.

## Test plan
- Reset, then alloc tag 3 → alloc_id_o=0, gnt=1. Port0 correct for tag 3 → slot 0 freed; chkpt_full_o stays 0.
- Alloc 8 slots with N_CHKPT=8 → chkpt_full_o=1. Ninth req → gnt=0. A free in cycle K → gnt=1 in cycle K+1.
- head=14, slots with tags 15, 1, 5. Mispredict tag 1 with dest_addr 0x400 → next cycle:
  - redirect_pc_o=0x400 and restore data = slot(tag 1);
  - slots 1 and 5 are freed, 15 is retained.
- Same cycle, port0 mispredicts tag 6 and port1 mispredicts tag 4, head=2 → tag 4 wins.
- During HOLD, mispredict tag 2 (older than latched tag 4) → FLUSH re-pulses with slot(tag 2). A later mispredict of tag 9 → ignored.
- Writeback tag 7 with no slot → err_lookup_o=1, no flush_o. Assert rst_i during HOLD → next cycle IDLE, all outputs 0, full=0.
